cutie_tcdm_arbiter: RTL and testbench
=====================================

CUTIE_TCDM_ARBITER -- requirements
Module: cutie_tcdm_arbiter

Interface
REQ-001 Parameter NUM_PORTS, default 4: number of requester (slave-side) TCDM ports, range 2..16.
REQ-002 Parameter MAX_OUTSTANDING, default 4: depth of the response-routing ID FIFO, range 1..16.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  reset, synchronous and active-high.
REQ-005 slv_req_i  input  NUM_PORTS x tcdm_req_t (70 bits each)  requester TCDM requests.
REQ-006 slv_rsp_o  output  NUM_PORTS x tcdm_rsp_t (35 bits each)  per-requester grant and response.
REQ-007 mst_req_o  output  tcdm_req_t  shared TCDM request to memory.
REQ-008 mst_rsp_i  input  tcdm_rsp_t  shared TCDM response from memory.
REQ-009 busy_o  output  1  high while any granted transaction awaits r_valid.
REQ-010 err_o  output  1  sticky flag: r_valid received with no outstanding transaction.

Function
REQ-011 A handshake occurs in a cycle where mst_req_o.req and mst_rsp_i.gnt are both high; every handshake (read or write) yields exactly one mst_rsp_i.r_valid, in order, one or more cycles later.
REQ-012 Eligible set: ports with slv_req_i[p].req high; when the ID FIFO holds MAX_OUTSTANDING entries, mst_req_o.req is 0 regardless of requests; a same-cycle pop does not lift the stall.
REQ-013 mst_req_o add/wen/wdata/be are the selected port's fields; mst_req_o.req = 1 when a port is selected and FIFO not full; zero-cycle combinational path.
REQ-014 slv_rsp_o[p].gnt = mst_rsp_i.gnt AND (p is selected) AND mst_req_o.req; all other gnt are 0.
REQ-015 Lock: while mst_req_o.req is high and gnt low, the selected port is registered and held in following cycles until its handshake; lock clears on handshake; a locked port dropping req (protocol violation) also clears lock.
REQ-016 On handshake, the selected port index (clog2(NUM_PORTS) bits) is pushed into the ID FIFO.
REQ-017 On mst_rsp_i.r_valid with FIFO non-empty: head popped; slv_rsp_o[head].r_valid = 1, others 0; r_rdata and r_opc broadcast to all ports unmodified.
REQ-018 On r_valid with FIFO empty: no pop, no port sees r_valid, err_o set to 1 from next cycle until reset.
REQ-019 Simultaneous push and pop with FIFO non-full: occupancy unchanged, order preserved; FIFO pointers wrap modulo MAX_OUTSTANDING.
REQ-020 busy_o = (FIFO occupancy != 0), registered-state derived, no combinational path from inputs.

Reset
REQ-021 With rst_i high at a clock edge: FIFO emptied, lock cleared, priority pointer = 0, err_o = 0.
REQ-022 During and after reset, until a new request: mst_req_o.req = 0, all slv gnt = 0, all slv r_valid = 0, busy_o = 0.
REQ-023 Reset mid-transaction discards outstanding IDs; subsequent stray r_valid sets err_o per REQ-018.

Configuration
REQ-024 Macro CUTIE_TCDM_ARB_RR_EN defined: round-robin; after a handshake by port p, priority pointer = (p+1) mod NUM_PORTS; selection = first eligible port at or after pointer.
REQ-025 Macro CUTIE_TCDM_ARB_RR_EN undefined: fixed priority, lowest eligible index wins, no pointer register; all other behaviour identical.

Verification
REQ-026 Single port 2 read, add=0x100, gnt same cycle, r_valid next cycle with rdata=0xDEADBEEF -> slv_rsp_o[2].gnt=1 in cycle 0, slv_rsp_o[2].r_valid=1 with 0xDEADBEEF in cycle 1, busy_o 1 for one cycle.
REQ-027 Ports 0..3 requesting continuously, gnt always 1, RR enabled -> grant order 0,1,2,3,0; without macro -> port 0 granted every cycle.
REQ-028 Port 1 requests, gnt held low 3 cycles while port 0 raises req -> mst_req_o stays port 1 fields, port 1 granted in cycle 3.
REQ-029 MAX_OUTSTANDING=4, 4 handshakes with no r_valid -> mst_req_o.req=0 on 5th; first r_valid pops port of 1st handshake; req resumes next cycle.
REQ-030 r_valid pulse after reset with no request -> no slv r_valid, err_o=1 next cycle, stays 1 until rst_i.
REQ-031 rst_i asserted with 2 outstanding -> busy_o=0 next cycle, both later r_valid pulses set err_o and route nowhere.

Source files
------------

// File: rtl/cutie_tcdm_arbiter_if.sv
// Bus bundle for cutie_tcdm_arbiter: NUM_PORTS requester TCDM ports plus the shared memory port.
// The slave modport is the arbiter's view; master is the view of whoever drives the requesters.
interface cutie_tcdm_arbiter_if #(
  parameter int unsigned NUM_PORTS = 4
);

  typedef struct packed {
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
  } tcdm_req_t;

  typedef struct packed {
    logic        gnt;
    logic        r_valid;
    logic [31:0] r_rdata;
    logic        r_opc;
  } tcdm_rsp_t;

  tcdm_req_t slv_req_i [NUM_PORTS];
  tcdm_rsp_t slv_rsp_o [NUM_PORTS];
  tcdm_req_t mst_req_o;
  tcdm_rsp_t mst_rsp_i;

  modport slave (
    input  slv_req_i,
    output slv_rsp_o,
    output mst_req_o,
    input  mst_rsp_i
  );

  modport master (
    output slv_req_i,
    input  slv_rsp_o,
    input  mst_req_o,
    output mst_rsp_i
  );

endinterface

// File: rtl/cutie_tcdm_arbiter.sv
// N-to-1 TCDM arbiter with an in-order ID FIFO that routes responses back to their requesters.
// Define CUTIE_TCDM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest wins).
module cutie_tcdm_arbiter #(
  parameter int unsigned NUM_PORTS       = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  cutie_tcdm_arbiter_if.slave  bus,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int unsigned IdxW = $clog2(NUM_PORTS);
  localparam int unsigned PtrW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CntW = $clog2(MAX_OUTSTANDING + 1);

  logic [NUM_PORTS-1:0] req_vec;

  logic            arb_valid;
  logic [IdxW-1:0] arb_idx;
  logic            lock_hit;
  logic            sel_valid;
  logic [IdxW-1:0] sel_idx;

  logic            fifo_full;
  logic            fifo_empty;
  logic            mst_req_valid;
  logic            handshake;
  logic            push;
  logic            pop;
  logic            stray_rsp;
  logic [IdxW-1:0] head_idx;

  logic [IdxW-1:0] id_mem_q [MAX_OUTSTANDING];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q, count_d;
  logic            lock_q;
  logic [IdxW-1:0] lock_idx_q;
  logic            err_q;

  function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(MAX_OUTSTANDING - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    req_vec = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      req_vec[p] = bus.slv_req_i[p].req;
    end
  end

`ifdef CUTIE_TCDM_ARB_RR_EN
  logic [IdxW-1:0] prio_q;
  logic [IdxW:0]   rr_cand;

  // Scan NUM_PORTS candidates starting at the pointer, wrapping at NUM_PORTS.
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    rr_cand   = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      rr_cand = {1'b0, prio_q} + (IdxW + 1)'(i);
      if (rr_cand >= (IdxW + 1)'(NUM_PORTS)) begin
        rr_cand = rr_cand - (IdxW + 1)'(NUM_PORTS);
      end
      if (!arb_valid && req_vec[rr_cand[IdxW-1:0]]) begin
        arb_valid = 1'b1;
        arb_idx   = rr_cand[IdxW-1:0];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prio_q <= '0;
    end else if (handshake) begin
      prio_q <= (sel_idx == IdxW'(NUM_PORTS - 1)) ? '0 : sel_idx + IdxW'(1);
    end
  end
`else
  always_comb begin
    arb_valid = 1'b0;
    arb_idx   = '0;
    for (int i = int'(NUM_PORTS) - 1; i >= 0; i--) begin
      if (req_vec[i]) begin
        arb_valid = 1'b1;
        arb_idx   = IdxW'(i);
      end
    end
  end
`endif

  // A port that saw req without gnt keeps the bus until its handshake (or until it drops req).
  assign lock_hit  = lock_q && req_vec[lock_idx_q];
  assign sel_valid = lock_hit || arb_valid;
  assign sel_idx   = lock_hit ? lock_idx_q : arb_idx;

  assign fifo_full     = (count_q == CntW'(MAX_OUTSTANDING));
  assign fifo_empty    = (count_q == '0);
  assign mst_req_valid = sel_valid && !fifo_full;
  assign handshake     = mst_req_valid && bus.mst_rsp_i.gnt;
  assign push          = handshake;
  assign pop           = bus.mst_rsp_i.r_valid && !fifo_empty;
  assign stray_rsp     = bus.mst_rsp_i.r_valid && fifo_empty;
  assign head_idx      = id_mem_q[rd_ptr_q];

  always_comb begin
    bus.mst_req_o     = bus.slv_req_i[sel_idx];
    bus.mst_req_o.req = mst_req_valid;
  end

  // Read data and opc are broadcast; only gnt and r_valid are steered.
  always_comb begin
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      bus.slv_rsp_o[p]         = bus.mst_rsp_i;
      bus.slv_rsp_o[p].gnt     = handshake && (sel_idx == IdxW'(p));
      bus.slv_rsp_o[p].r_valid = pop && (head_idx == IdxW'(p));
    end
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      id_mem_q[wr_ptr_q] <= sel_idx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      err_q      <= 1'b0;
    end else begin
      count_q <= count_d;
      if (push) begin
        wr_ptr_q <= ptr_next(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_next(rd_ptr_q);
      end
      if (handshake) begin
        lock_q <= 1'b0;
      end else if (mst_req_valid) begin
        lock_q     <= 1'b1;
        lock_idx_q <= sel_idx;
      end else if (lock_q && !lock_hit) begin
        lock_q <= 1'b0;
      end
      if (stray_rsp) begin
        err_q <= 1'b1;
      end
    end
  end

  assign busy_o = !fifo_empty;
  assign err_o  = err_q;

endmodule

// File: tb/tb_cutie_tcdm_arbiter.sv
// Self-checking bench for cutie_tcdm_arbiter: directed scenarios followed by random traffic,
// all compared against a queue-based reference model of the arbitration and response routing.
module tb_cutie_tcdm_arbiter;

  localparam int N    = 4;
  localparam int MAXO = 4;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic err;

  int tests = 0;
  int fails = 0;

  cutie_tcdm_arbiter_if #(.NUM_PORTS(N)) bus ();

  cutie_tcdm_arbiter #(
    .NUM_PORTS      (N),
    .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus),
    .busy_o(busy),
    .err_o (err)
  );

  always #5 clk = ~clk;

  // Reference model state: queue of granted port ids awaiting r_valid.
  int m_q[$];
  bit m_lock;
  int m_lock_p;
  bit m_err;
  int granted[$];
`ifdef CUTIE_TCDM_ARB_RR_EN
  int m_ptr;
  int exp027[5] = '{0, 1, 2, 3, 0};
`else
  int exp027[5] = '{0, 0, 0, 0, 0};
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int m_select();
    if (m_lock && bus.slv_req_i[m_lock_p].req) return m_lock_p;
    for (int i = 0; i < N; i++) begin
`ifdef CUTIE_TCDM_ARB_RR_EN
      if (bus.slv_req_i[(m_ptr + i) % N].req) return (m_ptr + i) % N;
`else
      if (bus.slv_req_i[i].req) return i;
`endif
    end
    return -1;
  endfunction

  function automatic void m_reset();
    m_q.delete();
    m_lock = 1'b0;
    m_err  = 1'b0;
`ifdef CUTIE_TCDM_ARB_RR_EN
    m_ptr = 0;
`endif
  endfunction

  // Check all outputs against the model; called mid-cycle after inputs settle.
  task automatic settle();
    int sel;
    bit mreq;
    #4;
    sel  = m_select();
    mreq = (sel >= 0) && (m_q.size() < MAXO);
    chk("mst_req", bus.mst_req_o.req, mreq);
    if (mreq) begin
      chk("mst_add", bus.mst_req_o.add, bus.slv_req_i[sel].add);
      chk("mst_wen", bus.mst_req_o.wen, bus.slv_req_i[sel].wen);
      chk("mst_wdata", bus.mst_req_o.wdata, bus.slv_req_i[sel].wdata);
      chk("mst_be", bus.mst_req_o.be, bus.slv_req_i[sel].be);
    end
    for (int p = 0; p < N; p++) begin
      bit eg;
      bit er;
      eg = bus.mst_rsp_i.gnt && mreq && (sel == p);
      er = 1'b0;
      if (bus.mst_rsp_i.r_valid && m_q.size() > 0) er = (m_q[0] == p);
      chk($sformatf("gnt%0d", p), bus.slv_rsp_o[p].gnt, eg);
      chk($sformatf("rvalid%0d", p), bus.slv_rsp_o[p].r_valid, er);
      chk($sformatf("rdata%0d", p), bus.slv_rsp_o[p].r_rdata, bus.mst_rsp_i.r_rdata);
      chk($sformatf("ropc%0d", p), bus.slv_rsp_o[p].r_opc, bus.mst_rsp_i.r_opc);
    end
    chk("busy", busy, m_q.size() != 0);
    chk("err", err, m_err);
  endtask

  // Advance one clock and apply the same edge to the model.
  task automatic tick();
    int sel;
    bit mreq;
    bit hs;
    bit rv;
    bit r;
    int pre;
    sel  = m_select();
    mreq = (sel >= 0) && (m_q.size() < MAXO);
    hs   = mreq && bus.mst_rsp_i.gnt;
    rv   = bus.mst_rsp_i.r_valid;
    r    = rst;
    @(posedge clk);
    if (r) begin
      m_reset();
    end else begin
      pre = m_q.size();
      if (rv) begin
        if (pre > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (hs) begin
        m_q.push_back(sel);
        granted.push_back(sel);
        m_lock = 1'b0;
`ifdef CUTIE_TCDM_ARB_RR_EN
        m_ptr = (sel + 1) % N;
`endif
      end else if (mreq) begin
        m_lock   = 1'b1;
        m_lock_p = sel;
      end else if (m_lock && !bus.slv_req_i[m_lock_p].req) begin
        m_lock = 1'b0;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < N; p++) bus.slv_req_i[p] = '0;
    bus.mst_rsp_i = '0;
  endtask

  task automatic set_req(input int p, input logic r, input logic [31:0] add);
    bus.slv_req_i[p].req   = r;
    bus.slv_req_i[p].add   = add;
    bus.slv_req_i[p].wen   = add[4];
    bus.slv_req_i[p].wdata = ~add;
    bus.slv_req_i[p].be    = add[3:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    settle();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    m_reset();
    @(posedge clk);
    #1;
    settle();
    tick();
    rst = 1'b0;
    settle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_req", bus.mst_req_o.req, 1'b0);
    tick();

    // Single read from port 2, response next cycle.
    set_req(2, 1'b1, 32'h100);
    bus.slv_req_i[2].wen = 1'b0;
    bus.mst_rsp_i.gnt = 1'b1;
    settle();
    chk("t026_gnt2", bus.slv_rsp_o[2].gnt, 1'b1);
    chk("t026_add", bus.mst_req_o.add, 32'h100);
    chk("t026_busy0", busy, 1'b0);
    tick();
    clear_inputs();
    bus.mst_rsp_i.r_valid = 1'b1;
    bus.mst_rsp_i.r_rdata = 32'hDEADBEEF;
    settle();
    chk("t026_rv2", bus.slv_rsp_o[2].r_valid, 1'b1);
    chk("t026_rdata", bus.slv_rsp_o[2].r_rdata, 32'hDEADBEEF);
    chk("t026_busy1", busy, 1'b1);
    tick();
    clear_inputs();
    settle();
    chk("t026_busy_end", busy, 1'b0);
    tick();

    // All ports requesting with gnt always high.
    do_reset();
    granted.delete();
    for (int p = 0; p < N; p++) set_req(p, 1'b1, 32'h40 + p);
    bus.mst_rsp_i.gnt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      bus.mst_rsp_i.r_valid = (c > 0);
      settle();
      tick();
    end
    chk("t027_count", granted.size(), 5);
    for (int i = 0; i < 5 && i < granted.size(); i++) begin
      chk($sformatf("t027_order%0d", i), granted[i], exp027[i]);
    end
    clear_inputs();
    bus.mst_rsp_i.r_valid = 1'b1;
    settle();
    tick();

    // Lock: port 1 held while port 0 joins and gnt stays low.
    do_reset();
    set_req(1, 1'b1, 32'h28);
    settle();
    chk("t028_add_c0", bus.mst_req_o.add, 32'h28);
    tick();
    set_req(0, 1'b1, 32'h10);
    for (int c = 1; c < 3; c++) begin
      settle();
      chk($sformatf("t028_add_c%0d", c), bus.mst_req_o.add, 32'h28);
      chk($sformatf("t028_gnt0_c%0d", c), bus.slv_rsp_o[0].gnt, 1'b0);
      tick();
    end
    bus.mst_rsp_i.gnt = 1'b1;
    settle();
    chk("t028_gnt1_c3", bus.slv_rsp_o[1].gnt, 1'b1);
    chk("t028_gnt0_c3", bus.slv_rsp_o[0].gnt, 1'b0);
    tick();
    set_req(1, 1'b0, 32'h0);
    settle();
    chk("t028_gnt0_after", bus.slv_rsp_o[0].gnt, 1'b1);
    tick();
    clear_inputs();
    bus.mst_rsp_i.r_valid = 1'b1;
    settle();
    tick();
    settle();
    tick();

    // FIFO full stall and resume.
    do_reset();
    bus.mst_rsp_i.gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      for (int p = 0; p < N; p++) set_req(p, p == k, 32'h200 + k);
      settle();
      tick();
    end
    for (int p = 0; p < N; p++) set_req(p, p == 0, 32'h300);
    settle();
    chk("t029_stall_req", bus.mst_req_o.req, 1'b0);
    chk("t029_stall_gnt0", bus.slv_rsp_o[0].gnt, 1'b0);
    chk("t029_busy", busy, 1'b1);
    tick();
    bus.mst_rsp_i.r_valid = 1'b1;
    bus.mst_rsp_i.r_rdata = 32'h1234;
    settle();
    chk("t029_pop_first", bus.slv_rsp_o[0].r_valid, 1'b1);
    chk("t029_pop_other", bus.slv_rsp_o[1].r_valid, 1'b0);
    chk("t029_same_cycle", bus.mst_req_o.req, 1'b0);
    tick();
    bus.mst_rsp_i.r_valid = 1'b0;
    settle();
    chk("t029_resume", bus.mst_req_o.req, 1'b1);
    chk("t029_resume_gnt", bus.slv_rsp_o[0].gnt, 1'b1);
    tick();
    clear_inputs();
    bus.mst_rsp_i.r_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      settle();
      tick();
    end

    // Stray r_valid with nothing outstanding.
    do_reset();
    bus.mst_rsp_i.r_valid = 1'b1;
    settle();
    for (int p = 0; p < N; p++) chk($sformatf("t030_rv%0d", p), bus.slv_rsp_o[p].r_valid, 1'b0);
    chk("t030_err_pre", err, 1'b0);
    tick();
    bus.mst_rsp_i.r_valid = 1'b0;
    settle();
    chk("t030_err_set", err, 1'b1);
    tick();
    for (int c = 0; c < 3; c++) begin
      settle();
      tick();
    end
    chk("t030_err_sticky", err, 1'b1);
    do_reset();
    settle();
    chk("t030_err_clr", err, 1'b0);
    tick();

    // Reset with two outstanding, then two stray responses.
    set_req(0, 1'b1, 32'h500);
    bus.mst_rsp_i.gnt = 1'b1;
    settle();
    tick();
    settle();
    tick();
    chk("t031_busy_pre", busy, 1'b1);
    do_reset();
    settle();
    chk("t031_busy_post", busy, 1'b0);
    tick();
    bus.mst_rsp_i.r_valid = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      for (int p = 0; p < N; p++) chk($sformatf("t031_rv%0d_%0d", p, c), bus.slv_rsp_o[p].r_valid, 1'b0);
      tick();
    end
    bus.mst_rsp_i.r_valid = 1'b0;
    settle();
    chk("t031_err", err, 1'b1);
    tick();

    // Random traffic.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 99) == 0);
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(0, 3) != 0 || !bus.slv_req_i[p].req) begin
          bus.slv_req_i[p].req   = $urandom_range(0, 1);
          bus.slv_req_i[p].add   = $urandom();
          bus.slv_req_i[p].wen   = $urandom_range(0, 1);
          bus.slv_req_i[p].wdata = $urandom();
          bus.slv_req_i[p].be    = 4'($urandom());
        end
      end
      bus.mst_rsp_i.gnt     = ($urandom_range(0, 9) < 6);
      bus.mst_rsp_i.r_valid = (m_q.size() > 0) ? ($urandom_range(0, 1) == 1)
                                                : ($urandom_range(0, 149) == 0);
      bus.mst_rsp_i.r_rdata = $urandom();
      bus.mst_rsp_i.r_opc   = $urandom_range(0, 1);
      settle();
      tick();
    end
    rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
